// File: rtl/grf_wb_sink_pkg.sv
// rtl/grf_wb_sink_pkg.sv - shared pipeline constants and trace entry layout
package grf_wb_sink_pkg;

  localparam int          DATA_W   = 32;
  localparam int          ADDR_W   = 5;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam int          TRACE_W  = 2 * DATA_W + ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/grf_wb_sink_trace_fifo.sv
// rtl/grf_wb_sink_trace_fifo.sv - write-trace FIFO with sticky drop flag
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 69
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_overflow
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_FULL);
  // An empty FIFO cannot pop, so push+pop on empty degenerates to push only.
  assign w_pop     = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + PW'(1);
      if (w_pop)     r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + {{PW{1'b0}}, w_push_ok} - {{PW{1'b0}}, w_pop};
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_din;
  end

  assign o_valid    = !w_empty;
  assign o_dout     = w_empty ? '0 : r_mem[r_rptr];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/grf_wb_sink.sv
// rtl/grf_wb_sink.sv - register file write-back sink with write-trace FIFO
module grf_wb_sink
  import grf_wb_sink_pkg::*;
#(
  parameter int TRACE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_4,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] WD,
  input  logic [DATA_W-1:0] PC_4,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [DATA_W-1:0] trace_pc,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [DATA_W-1:0] trace_data,
  output logic              trace_overflow
);

  logic [DATA_W-1:0] r_regs [32];
  logic              w_we;
  trace_entry_t      w_entry;
  trace_entry_t      w_head;
  logic [TRACE_W-1:0] w_head_bits;

  assign w_we = RegWrite_4 && (A3 != REG_ZERO);

  // Entry 0 is cleared on reset and never written, so it stays constant zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[A3] <= WD;
    end
  end

  always_comb begin
    RD1 = r_regs[A1];
    if (A1 == REG_ZERO)          RD1 = '0;
    else if (w_we && (A3 == A1)) RD1 = WD;
  end

  always_comb begin
    RD2 = r_regs[A2];
    if (A2 == REG_ZERO)          RD2 = '0;
    else if (w_we && (A3 == A2)) RD2 = WD;
  end

  assign w_entry = '{pc: PC_4, addr: A3, data: WD};

  trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TRACE_W)
  ) u_trace_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (w_we),
    .i_pop      (trace_ready),
    .i_din      (w_entry),
    .o_valid    (trace_valid),
    .o_dout     (w_head_bits),
    .o_overflow (trace_overflow)
  );

  assign w_head     = w_head_bits;
  assign trace_pc   = w_head.pc;
  assign trace_addr = w_head.addr;
  assign trace_data = w_head.data;

endmodule

// File: tb/tb_grf_wb_sink.sv
// tb/tb_grf_wb_sink.sv - randomized self-checking bench for grf_wb_sink
module tb_grf_wb_sink;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        RegWrite_4;
  logic [4:0]  A3;
  logic [31:0] WD;
  logic [31:0] PC_4;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;

  grf_wb_sink #(.TRACE_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .RegWrite_4     (RegWrite_4),
    .A3             (A3),
    .WD             (WD),
    .PC_4           (PC_4),
    .A1             (A1),
    .A2             (A2),
    .RD1            (RD1),
    .RD2            (RD2),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_pc       (trace_pc),
    .trace_addr     (trace_addr),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic [31:0] m_regs [32];
  ent_t        m_q [$];
  bit          m_ovf;
  int          n_cmp = 0;
  int          n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  // One clock edge; the model applies the architectural rules to the inputs held across it.
  task automatic step();
    bit eff;
    bit pop;
    eff = RegWrite_4 && (A3 != 5'd0);
    pop = trace_ready && (m_q.size() > 0);
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (eff) begin
      m_regs[A3] = WD;
      if (m_q.size() < DEPTH) m_q.push_back('{pc: PC_4, addr: A3, data: WD});
      else m_ovf = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    RegWrite_4 = 0; A3 = 0; WD = 0; PC_4 = 0; A1 = 0; A2 = 0; trace_ready = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_clear();
    #12;
    A1 = 5'd8;
    #1;
    n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
    n_cmp++; if (trace_overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", trace_overflow); end
    n_cmp++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL reset_rd1: got %h want 0", RD1); end
    n_cmp++; if ({trace_pc, trace_addr, trace_data} !== 69'd0) begin n_err++; $display("FAIL reset_head: got %h/%h/%h want 0", trace_pc, trace_addr, trace_data); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write_read();
    RegWrite_4 = 1; A3 = 5'd8; WD = 32'h1234; PC_4 = 32'h0000_0400; trace_ready = 0;
    step();
    RegWrite_4 = 0; A1 = 5'd8;
    #1;
    n_cmp++; if (RD1 !== 32'h1234) begin n_err++; $display("FAIL wr_rd1: got %h want 00001234", RD1); end
    n_cmp++; if (trace_valid !== 1'b1) begin n_err++; $display("FAIL wr_valid: got %b want 1", trace_valid); end
    n_cmp++; if (trace_pc !== 32'h400 || trace_addr !== 5'd8 || trace_data !== 32'h1234)
      begin n_err++; $display("FAIL wr_head: got %h/%0d/%h want 00000400/8/00001234", trace_pc, trace_addr, trace_data); end
    trace_ready = 1;
    step();
    trace_ready = 0;
    n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL wr_pop: valid %b want 0", trace_valid); end
  endtask

  task automatic test_zero_reg();
    RegWrite_4 = 1; A3 = 5'd0; WD = 32'hFFFF_FFFF; A1 = 5'd0; trace_ready = 0;
    #1;
    n_cmp++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL zero_bypass: got %h want 0", RD1); end
    step();
    RegWrite_4 = 0;
    #1;
    n_cmp++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL zero_rd1: got %h want 0", RD1); end
    n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL zero_notrace: valid %b want 0", trace_valid); end
  endtask

  task automatic test_bypass();
    RegWrite_4 = 1; A3 = 5'd5; WD = 32'hA5A5_A5A5; A2 = 5'd5; A1 = 5'd8;
    #1;
    n_cmp++; if (RD2 !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL bypass_rd2: got %h want a5a5a5a5", RD2); end
    n_cmp++; if (RD1 !== 32'h1234) begin n_err++; $display("FAIL bypass_rd1: got %h want 00001234", RD1); end
    step();
    RegWrite_4 = 0; trace_ready = 1;
    step();
    trace_ready = 0;
  endtask

  task automatic test_overflow();
    int got;
    do_reset();
    trace_ready = 0;
    for (int k = 0; k < 5; k++) begin
      RegWrite_4 = 1; A3 = 5'(k + 1); WD = 32'h1000_0000 + k; PC_4 = 32'h100 + 4 * k;
      step();
      if (k == 3) begin
        n_cmp++; if (trace_overflow !== 1'b0) begin n_err++; $display("FAIL ovf_at4: got %b want 0", trace_overflow); end
      end
    end
    RegWrite_4 = 0;
    n_cmp++; if (trace_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_at5: got %b want 1", trace_overflow); end
    got = 0;
    trace_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (trace_valid === 1'b1) begin
        n_cmp++;
        if (trace_pc !== 32'h100 + 4 * got || trace_addr !== 5'(got + 1) || trace_data !== 32'h1000_0000 + got)
          begin n_err++; $display("FAIL ovf_order%0d: got %h/%0d/%h want %h/%0d/%h", got, trace_pc, trace_addr, trace_data,
                                  32'h100 + 4 * got, got + 1, 32'h1000_0000 + got); end
        got++;
      end
      step();
    end
    trace_ready = 0;
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL ovf_drain_count: got %0d want 4", got); end
    n_cmp++; if (trace_overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", trace_overflow); end
  endtask

  task automatic test_full_pushpop();
    int got;
    do_reset();
    trace_ready = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) trace_ready = 1;
      RegWrite_4 = 1; A3 = 5'(k + 1); WD = 32'h2000_0000 + k; PC_4 = 32'h200 + 4 * k;
      step();
    end
    RegWrite_4 = 0; trace_ready = 0;
    n_cmp++; if (trace_overflow !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf: got %b want 0", trace_overflow); end
    got = 0;
    trace_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if (trace_valid === 1'b1) begin
        n_cmp++;
        if (trace_pc !== 32'h200 + 4 * (got + 1) || trace_data !== 32'h2000_0000 + got + 1)
          begin n_err++; $display("FAIL full_pp_order%0d: got %h/%h want %h/%h", got, trace_pc, trace_data,
                                  32'h200 + 4 * (got + 1), 32'h2000_0000 + got + 1); end
        got++;
      end
      step();
    end
    trace_ready = 0;
    n_cmp++; if (got != 4) begin n_err++; $display("FAIL full_pp_count: got %0d want 4", got); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    trace_ready = 0;
    RegWrite_4 = 1; A3 = 5'd8; WD = 32'hCAFE_0008; PC_4 = 32'h300; step();
    A3 = 5'd9; WD = 32'hCAFE_0009; PC_4 = 32'h304; step();
    RegWrite_4 = 0; A1 = 5'd8;
    #1;
    n_cmp++; if (trace_valid !== 1'b1 || RD1 !== 32'hCAFE_0008) begin n_err++; $display("FAIL mid_pre: valid %b rd1 %h want 1/cafe0008", trace_valid, RD1); end
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (trace_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", trace_valid); end
    n_cmp++; if (RD1 !== 32'd0) begin n_err++; $display("FAIL mid_rd1: got %h want 0", RD1); end
    RegWrite_4 = 1; A3 = 5'd9; WD = 32'h5555_5555;
    @(posedge clk);
    #2;
    RegWrite_4 = 0; A1 = 5'd9;
    reset = 1'b1;
    #1;
    n_cmp++; if (RD1 !== 32'd0 || trace_valid !== 1'b0) begin n_err++; $display("FAIL mid_discard: rd1 %h valid %b want 0/0", RD1, trace_valid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    ent_t        h;
    bit          eff;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      RegWrite_4  = ($urandom_range(0, 3) != 0);
      A3          = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      WD          = $urandom;
      PC_4        = $urandom;
      A1          = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
      A2          = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom_range(0, 31));
      trace_ready = (c < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      #1;
      eff = RegWrite_4 && (A3 != 0);
      e1 = (A1 == 0) ? 32'd0 : (eff && A3 == A1) ? WD : m_regs[A1];
      e2 = (A2 == 0) ? 32'd0 : (eff && A3 == A2) ? WD : m_regs[A2];
      h  = (m_q.size() > 0) ? m_q[0] : '{pc: 32'd0, addr: 5'd0, data: 32'd0};
      n_cmp++; if (RD1 !== e1) begin n_err++; $display("FAIL rnd_rd1 c%0d: got %h want %h", c, RD1, e1); end
      n_cmp++; if (RD2 !== e2) begin n_err++; $display("FAIL rnd_rd2 c%0d: got %h want %h", c, RD2, e2); end
      n_cmp++; if (trace_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid c%0d: got %b want %b", c, trace_valid, m_q.size() > 0); end
      n_cmp++; if (trace_pc !== h.pc || trace_addr !== h.addr || trace_data !== h.data)
        begin n_err++; $display("FAIL rnd_head c%0d: got %h/%0d/%h want %h/%0d/%h", c, trace_pc, trace_addr, trace_data, h.pc, h.addr, h.data); end
      n_cmp++; if (trace_overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c%0d: got %b want %b", c, trace_overflow, m_ovf); end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_overflow();
    test_full_pushpop();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grf_wb_sink.md
GRF_WB_SINK -- requirements
Module: grf_wb_sink

Interface
REQ-001 SHALL have parameter TRACE_DEPTH, default 4, meaning the number of write-trace FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk  input  1  meaning the single pipeline clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning the asynchronous, active-low reset.
REQ-004 SHALL have port RegWrite_4  input  1  meaning the write-back enable from the WB stage.
REQ-005 SHALL have port A3  input  5  meaning the write register index, already resolved from RegDst.
REQ-006 SHALL have port WD  input  32  meaning the write data (GRF_WD from WB).
REQ-007 SHALL have port PC_4  input  32  meaning the PC of the instruction in WB.
REQ-008 SHALL have port A1  input  5  meaning the first read index.
REQ-009 SHALL have port A2  input  5  meaning the second read index.
REQ-010 SHALL have port RD1  output  32  meaning the first read data.
REQ-011 SHALL have port RD2  output  32  meaning the second read data.
REQ-012 SHALL have port trace_valid  output  1  meaning the trace head entry is valid.
REQ-013 SHALL have port trace_ready  input  1  meaning the consumer accepts the head entry.
REQ-014 SHALL have port trace_pc  output  32  meaning the head entry PC.
REQ-015 SHALL have port trace_addr  output  5  meaning the head entry register index.
REQ-016 SHALL have port trace_data  output  32  meaning the head entry data.
REQ-017 SHALL have port trace_overflow  output  1  meaning the sticky flag set when a write was dropped because the FIFO was full.

Function
REQ-018 SHALL treat a write as effective exactly when RegWrite_4=1 and A3!=0; only an effective write updates register A3 with WD at the rising clk edge.
REQ-019 SHALL hold register 0 at 0 permanently; reading index 0 returns 0.
REQ-020 SHALL drive RD1 and RD2 combinationally from the array, with same-cycle bypass: when a write is effective and A3==A1 (or A2), the matching RD output is WD.
REQ-021 SHALL push {PC_4, A3, WD} into the trace FIFO on every effective write; ineffective writes are never traced.
REQ-022 SHALL pop the head entry on a rising edge where trace_valid=1 and trace_ready=1.
REQ-023 SHALL assert trace_valid exactly when the FIFO is non-empty, and drive trace_pc, trace_addr and trace_data to 0 when it is empty.
REQ-024 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle, leaving occupancy unchanged.
REQ-025 SHALL drop a push when the FIFO is full with no pop that cycle, and set trace_overflow; the register-array write still occurs.
REQ-026 SHALL keep trace_overflow set until reset.
REQ-027 SHALL wrap the read and write pointers modulo TRACE_DEPTH, with an occupancy counter of log2(TRACE_DEPTH)+1 bits.
REQ-028 SHALL, on a push and pop in the same cycle when the FIFO is empty, push only; the new entry becomes visible on the next cycle (one-cycle push-to-valid latency).

Reset
REQ-029 SHALL, on reset=0 at any time, asynchronously clear all 31 writable registers to 0, empty the FIFO (pointers and count to 0), clear trace_overflow, and drive trace_valid low.
REQ-030 SHALL discard a write or trace push coinciding with active reset; normal operation resumes at the first rising edge after reset returns to 1.

Structure
REQ-031 SHALL take REG_ZERO (5'd0), DATA_W (32) and ADDR_W (5) from the shared pipeline constants package.
REQ-032 SHALL implement the trace buffer as a single sub-module, trace_fifo, parameterised by depth and entry width (69 bits).

Verification
REQ-033 SHALL cover: write A3=8, WD=0x1234 -> next cycle RD1(A1=8)=0x1234; a trace entry with pc=PC_4, addr=8, data=0x1234 appears.
REQ-034 SHALL cover: RegWrite_4=1, A3=0, WD=0xFFFFFFFF -> RD1(A1=0)=0, no trace push.
REQ-035 SHALL cover: same-cycle write A3=5, WD=0xA5A5A5A5 with A2=5 -> RD2=0xA5A5A5A5 in that cycle.
REQ-036 SHALL cover: trace_ready=0, 5 effective writes at depth 4 -> first 4 retained in order, trace_overflow=1 after the 5th; draining yields exactly 4 entries.
REQ-037 SHALL cover: FIFO full, trace_ready=1 during a new write -> no overflow, count stays 4, order preserved.
REQ-038 SHALL cover: reset pulled low mid-stream with 2 entries queued -> trace_valid=0 and RD1(A1=8)=0 immediately.
